decoder_regfile: RTL and testbench
==================================

// Module: decoder_regfile
// PURPOSE
//  Decode stage sitting directly downstream of IFetch in the single-cycle RV32I core.
//  Takes IFetch's instruction and holds the 32x32 architectural register file.
//  Produces rs1/rs2 operands, the sign-extended imm32 (fed back to IFetch for jal/branch targets), and rd.
//  Commits the write-back result on the clock edge.
// PARAMETERS
//  DATA_W   32            register / operand width
//  REG_CNT  32            number of architectural registers; index width is clog2(REG_CNT) = 5
//  SP_INIT  32'h0000_7FFC reset value of x2 (sp); all other registers reset to 0
// PORTS
//  clk          in   1   core clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  instruction  in   32  current instruction from IFetch
//  reg_write    in   1   write-enable from the controller for this instruction
//  wb_data      in   32  write-back value (ALU result / load data / pc+4)
//  rs1_data     out  32  value of x[instruction[19:15]]
//  rs2_data     out  32  value of x[instruction[24:20]]
//  imm32        out  32  sign-extended immediate for the instruction's format
//  rd_addr      out  5   instruction[11:7]
//  illegal      out  1   opcode not in the supported set
//  dbg_addr     in   5   debug read index (board I/O / seven-segment display)
//  dbg_data     out  32  value of x[dbg_addr]
// BEHAVIOUR
//  Reads
//  - rs1_data, rs2_data and dbg_data are combinational reads of the current register state.
//  - Index 0 always reads 0.
//  - There is no same-cycle write-to-read bypass: a read returns the pre-edge value. This is correct for single-cycle operation.
//  Writes
//  - On rising edge, if reg_write && !illegal && rd_addr != 0, then x[rd_addr] <= wb_data.
//  - Writes to x0 are discarded; x0 is never stored, so it is hardwired to 0.
//  Reset
//  - On rising edge with rst=1: x2 <= SP_INIT and every other register <= 0.
//  - rst has priority over a simultaneous write.
//  - A reset asserted mid-program takes effect at the next edge. The first read after it returns reset values.
//  - All outputs are combinational functions of instruction plus register state, so after reset they show the decoded current instruction against reset contents.
//  Immediate generation (combinational, keyed on instruction[6:0])
//  - I-type (0010011, 0000011, 1100111, 1110011): sext(ins[31:20]).
//  - S-type (0100011): sext({ins[31:25], ins[11:7]}).
//  - B-type (1100011): sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
//  - U-type (0110111, 0010111): {ins[31:12], 12'b0}.
//  - J-type (1101111): sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
//  - R-type (0110011): imm32 = 0.
//  Illegal opcodes
//  - Any opcode other than those listed: illegal = 1, imm32 = 0, and the write is suppressed.
//  - Register state is left untouched.
//  Latency
//  - Reads and decode: 0 cycles.
//  - A write becomes visible to reads on the cycle after the edge.
// STRUCTURE
//  - Shared header riscv_defs.vh holds:
//    - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS;
//    - immediate-format encoding IMM_I/S/B/U/J/NONE;
//    - the register index width.
//  - One sub-module, imm_gen: purely combinational, instruction -> {imm32, illegal}.
//  - The register array and its write/reset logic stay in decoder_regfile.
// TESTING
//  1. Reset: hold rst=1 for 1 edge, then release. Debug reads of x0..x31 -> x2 = 32'h0000_7FFC, all others 0.
//  2. Write/read: instruction 32'h00500093 (addi x1,x0,5), reg_write=1, wb_data=5, one edge.
//     Then instruction 32'h002081B3 (add x3,x1,x2) -> rs1_data=5, rs2_data=32'h7FFC, rd_addr=3.
//  3. x0 protection: instruction 32'h00700013 with reg_write=1, wb_data=32'hDEADBEEF. Next cycle dbg_addr=0 -> dbg_data=0.
//  4. Immediates, each with the required imm32:
//     - 32'hFFC00093 -> 32'hFFFFFFFC;
//     - 32'hFE112E23 (sw) -> 32'hFFFFFFFC;
//     - 32'hFE000EE3 (beq) -> 32'hFFFFFFFC;
//     - 32'h123450B7 (lui) -> 32'h12345000;
//     - 32'h0080006F (jal) -> 32'h00000008.
//  5. Illegal opcode: instruction 32'h0000007F, reg_write=1, wb_data=9 -> illegal=1, imm32=0, x[rd] unchanged next cycle.
//  6. Reset priority: rst=1 and a write to x5 with wb_data=7 on the same edge -> x5=0 afterwards.
//     Then write x5=7 with rst=0 -> dbg_data=7 on the following cycle.

Source files
------------

// File: rtl/decoder_regfile_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and register-index width.
package decoder_regfile_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int IDX_W   = $clog2(REG_CNT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_ILLEGAL
  } imm_fmt_e;

  // Opcode classification; IMM_ILLEGAL marks anything outside the supported set.
  function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR, OP_SYS: fmt = IMM_I;
      OP_STORE:                       fmt = IMM_S;
      OP_BRANCH:                      fmt = IMM_B;
      OP_LUI, OP_AUIPC:               fmt = IMM_U;
      OP_JAL:                         fmt = IMM_J;
      OP_R:                           fmt = IMM_NONE;
      default:                        fmt = IMM_ILLEGAL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decoder_regfile_imm_gen.sv
// Combinational immediate generator: instruction -> sign-extended imm32 and illegal flag.
module imm_gen
  import decoder_regfile_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm32,
  output logic        illegal
);

  imm_fmt_e fmt;

  always_comb begin
    fmt     = decode_fmt(instruction[6:0]);
    imm32   = 32'h0;
    illegal = 1'b0;
    case (fmt)
      IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm32 = {instruction[31:12], 12'h000};
      IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      IMM_ILLEGAL: illegal = 1'b1;
      default: imm32 = 32'h0;
    endcase
  end

endmodule

// File: rtl/decoder_regfile.sv
// RV32I decode stage: operand reads, immediate decode and the 32x32 register file.
module decoder_regfile
  import decoder_regfile_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [31:0]       imm32,
  output logic [IDX_W-1:0]  rd_addr,
  output logic              illegal,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // x0 is never stored; the array starts at index 1.
  logic [DATA_W-1:0] regs_q [1:REG_CNT-1];
  logic [DATA_W-1:0] regs_d [1:REG_CNT-1];

  logic [IDX_W-1:0] rs1_addr;
  logic [IDX_W-1:0] rs2_addr;

  assign rs1_addr = instruction[19:15];
  assign rs2_addr = instruction[24:20];
  assign rd_addr  = instruction[11:7];

  imm_gen u_imm_gen (
    .instruction (instruction),
    .imm32       (imm32),
    .illegal     (illegal)
  );

  always_comb begin
    for (int i = 1; i < REG_CNT; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_write && !illegal && (rd_addr == IDX_W'(i))) begin
        regs_d[i] = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_CNT; i++) begin
        regs_q[i] <= (i == 2) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      for (int i = 1; i < REG_CNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see pre-edge state only; index 0 falls through to the zero default.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    for (int i = 1; i < REG_CNT; i++) begin
      if (rs1_addr == IDX_W'(i)) rs1_data = regs_q[i];
      if (rs2_addr == IDX_W'(i)) rs2_data = regs_q[i];
      if (dbg_addr == IDX_W'(i)) dbg_data = regs_q[i];
    end
  end

endmodule

// File: tb/tb_decoder_regfile.sv
// Directed self-checking bench for decoder_regfile.
module tb_decoder_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        reg_write;
  logic [31:0] wb_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm32;
  logic [4:0]  rd_addr;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .reg_write   (reg_write),
    .wb_data     (wb_data),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm32       (imm32),
    .rd_addr     (rd_addr),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1; instruction = 32'h00000013; reg_write = 1'b0; wb_data = 32'h0; dbg_addr = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      exp = (i == 2) ? 32'h0000_7FFC : 32'h0;
      vectors++;
      if (dbg_data !== exp) begin
        miscompares++;
        $display("FAIL reset_x%0d: got %h expected %h", i, dbg_data, exp);
      end
    end
    $display("test_reset: debug-read x0..x31 after reset");
  endtask

  task automatic test_write_read();
    instruction = 32'h00500093; reg_write = 1'b1; wb_data = 32'd5;
    #1;
    vectors++;
    if (imm32 !== 32'd5 || rd_addr !== 5'd1 || rs1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL addi_decode: imm %h rd %0d rs1 %h expected 00000005 1 00000000", imm32, rd_addr, rs1_data);
    end
    @(posedge clk); #1;
    reg_write = 1'b0; instruction = 32'h002081B3;
    #1;
    vectors++;
    if (rs1_data !== 32'd5 || rs2_data !== 32'h7FFC || rd_addr !== 5'd3) begin
      miscompares++;
      $display("FAIL add_read: rs1 %h rs2 %h rd %0d expected 00000005 00007ffc 3", rs1_data, rs2_data, rd_addr);
    end
    vectors++;
    if (imm32 !== 32'h0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL rtype_imm: imm %h illegal %b expected 00000000 0", imm32, illegal);
    end
    $display("test_write_read: addi x1=5 then add x3,x1,x2");
  endtask

  task automatic test_x0();
    instruction = 32'h00700013; reg_write = 1'b1; wb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    reg_write = 1'b0; dbg_addr = 5'd0;
    #1;
    vectors++;
    if (dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_protect: got %h expected 00000000", dbg_data);
    end
    dbg_addr = 5'd1;
    #1;
    vectors++;
    if (dbg_data !== 32'd5) begin
      miscompares++;
      $display("FAIL x1_keep: got %h expected 00000005", dbg_data);
    end
    $display("test_x0: write to x0 discarded");
  endtask

  task automatic test_imm();
    logic [31:0] ins_tab [7] = '{32'hFFC00093, 32'hFE112E23, 32'hFE000EE3, 32'h123450B7,
                                 32'h0080006F, 32'hABCDE097, 32'h80002083};
    logic [31:0] exp_tab [7] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                                 32'h00000008, 32'hABCDE000, 32'hFFFFF800};
    reg_write = 1'b0;
    for (int i = 0; i < 7; i++) begin
      instruction = ins_tab[i];
      #1;
      vectors++;
      if (imm32 !== exp_tab[i] || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL imm_%0d: ins %h imm %h illegal %b expected %h 0", i, ins_tab[i], imm32, illegal, exp_tab[i]);
      end
      $display("test_imm: ins %h imm32 %h", ins_tab[i], imm32);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins_tab [2] = '{32'h0000007F, 32'h000000FF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instruction = ins_tab[i]; reg_write = 1'b1; wb_data = 32'd9;
      #1;
      vectors++;
      if (illegal !== 1'b1 || imm32 !== 32'h0) begin
        miscompares++;
        $display("FAIL illegal_flag_%0d: illegal %b imm %h expected 1 00000000", i, illegal, imm32);
      end
      @(posedge clk); #1;
      reg_write = 1'b0; dbg_addr = rd_addr;
      #1;
      vectors++;
      if (dbg_data !== ((i == 0) ? 32'h0 : 32'd5)) begin
        miscompares++;
        $display("FAIL illegal_nowrite_%0d: x%0d got %h", i, dbg_addr, dbg_data);
      end
      $display("test_illegal: ins %h suppressed write to x%0d", ins_tab[i], rd_addr);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    instruction = 32'h00700293; reg_write = 1'b1; wb_data = 32'd7; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; reg_write = 1'b0;
    dbg_addr = 5'd5;
    #1;
    vectors++;
    if (dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_prio_x5: got %h expected 00000000", dbg_data);
    end
    dbg_addr = 5'd1;
    #1;
    vectors++;
    if (dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_clears_x1: got %h expected 00000000", dbg_data);
    end
    // addi x5,x5,7 writing x5 while reading it: no bypass before the edge.
    instruction = 32'h00728293; reg_write = 1'b1; wb_data = 32'd7;
    #1;
    vectors++;
    if (rs1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL no_bypass: rs1 got %h expected 00000000", rs1_data);
    end
    @(posedge clk); #1;
    reg_write = 1'b0; dbg_addr = 5'd5;
    #1;
    vectors++;
    if (dbg_data !== 32'd7 || rs1_data !== 32'd7) begin
      miscompares++;
      $display("FAIL x5_write: dbg %h rs1 %h expected 00000007 00000007", dbg_data, rs1_data);
    end
    $display("test_reset_priority: rst beats write, then x5=7");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_imm();
    test_illegal();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
